// File: rtl/bus_stream_ser_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_stream_ser_pkg
// Brief   : Shared header codes, FSM state type and packet-length helper.
// Revision: 1.0 - initial release
// ============================================================================
package bus_stream_ser_pkg;

  localparam int HDR_FULL = 1;
  localparam int HDR_SEQ  = 2;

`ifdef BUS_STREAM_SER_CHK_EN
  localparam int CHK_BEATS = 1;
`else
  localparam int CHK_BEATS = 0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_ADR  = 3'd2,
    ST_DAT  = 3'd3,
    ST_CHK  = 3'd4
  } state_e;

  function automatic int pkt_beats(input int aw, input int dw, input int sw, input bit seq);
    return 1 + (seq ? 0 : aw / sw) + dw / sw + CHK_BEATS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_stream_ser_if.sv
`default_nettype none
// ============================================================================
// Module  : bus_stream_ser_if
// Brief   : Bus-side write port and stream-side beat port of the serializer.
// Revision: 1.0 - initial release
// ============================================================================
interface bus_stream_ser_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = 8
);

  logic          bsi_vld;
  logic [AW-1:0] bsi_adr;
  logic [DW-1:0] bsi_dat;
  logic          bsi_rdy;
  logic          sto_vld;
  logic [SW-1:0] sto_bus;
  logic          sto_lst;
  logic          sto_rdy;

  modport master (
    output bsi_vld, bsi_adr, bsi_dat, sto_rdy,
    input  bsi_rdy, sto_vld, sto_bus, sto_lst
  );

  modport slave (
    input  bsi_vld, bsi_adr, bsi_dat, sto_rdy,
    output bsi_rdy, sto_vld, sto_bus, sto_lst
  );

endinterface
`default_nettype wire

// File: rtl/bus_stream_ser_shift.sv
`default_nettype none
// ============================================================================
// Module  : bus_stream_shift
// Brief   : Parallel-load register that shifts right by one SW beat per step.
// Revision: 1.0 - initial release
// ============================================================================
module bus_stream_shift #(
  parameter int WIDTH = 32,
  parameter int SW    = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load_i,
  input  wire logic [WIDTH-1:0] load_val_i,
  input  wire logic             shift_i,
  output      logic [SW-1:0]    beat_o
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= load_val_i;
    end else if (shift_i) begin
      sr_q <= sr_q >> SW;
    end
  end

  assign beat_o = sr_q[SW-1:0];

endmodule
`default_nettype wire

// File: rtl/bus_stream_ser.sv
`default_nettype none
// ============================================================================
// Module  : bus_stream_ser
// Brief   : Bus-write to framed stream serializer with sequential-address
//           compression; BUS_STREAM_SER_CHK_EN appends an XOR checksum beat.
// Revision: 1.0 - initial release
// ============================================================================
module bus_stream_ser
  import bus_stream_ser_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int SW  = 8,
  parameter int SEQ = 1
) (
  input wire logic         clk,
  input wire logic         rst,
  bus_stream_ser_if.slave  bus
);

  localparam int BEATS_MAX = ((AW > DW) ? AW : DW) / SW;
  localparam int CW        = (BEATS_MAX > 1) ? $clog2(BEATS_MAX) : 1;
  localparam logic [CW-1:0] ADR_LAST = CW'(AW / SW - 1);
  localparam logic [CW-1:0] DAT_LAST = CW'(DW / SW - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_q;
  logic          seq_q;
  logic          lad_vld_q;
  logic [AW-1:0] last_adr_q;

  logic          w_bsi_xfer;
  logic          w_seq;
  logic [AW-1:0] w_adr_inc;
  logic          w_adr_shift;
  logic          w_dat_shift;
  logic [SW-1:0] w_adr_beat;
  logic [SW-1:0] w_dat_beat;
  logic [SW-1:0] w_chk_beat;
  logic          w_sto_vld;
  logic          w_sto_lst;
  logic [SW-1:0] w_sto_bus;

  // rdy_q is only ever high in IDLE, so it alone qualifies the bus transfer
  assign w_bsi_xfer  = bus.bsi_vld & rdy_q;
  assign w_adr_inc   = last_adr_q + AW'(1);
  assign w_seq       = (SEQ != 0) && lad_vld_q && (bus.bsi_adr == w_adr_inc);
  assign w_adr_shift = (state_q == ST_ADR) && bus.sto_rdy;
  assign w_dat_shift = (state_q == ST_DAT) && bus.sto_rdy;

  bus_stream_shift #(.WIDTH(AW), .SW(SW)) u_adr_shift (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_bsi_xfer),
    .load_val_i (bus.bsi_adr),
    .shift_i    (w_adr_shift),
    .beat_o     (w_adr_beat)
  );

  bus_stream_shift #(.WIDTH(DW), .SW(SW)) u_dat_shift (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_bsi_xfer),
    .load_val_i (bus.bsi_dat),
    .shift_i    (w_dat_shift),
    .beat_o     (w_dat_beat)
  );

`ifdef BUS_STREAM_SER_CHK_EN
  logic [SW-1:0] chk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_q <= '0;
    end else if (w_bsi_xfer) begin
      chk_q <= w_seq ? SW'(HDR_SEQ) : SW'(HDR_FULL);
    end else if (w_adr_shift || w_dat_shift) begin
      chk_q <= chk_q ^ w_sto_bus;
    end
  end

  assign w_chk_beat = chk_q;
`else
  assign w_chk_beat = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rdy_q      <= 1'b0;
      seq_q      <= 1'b0;
      lad_vld_q  <= 1'b0;
      last_adr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_d == ST_IDLE);
      if (w_bsi_xfer) begin
        seq_q      <= w_seq;
        lad_vld_q  <= 1'b1;
        last_adr_q <= bus.bsi_adr;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_sto_vld = 1'b0;
    w_sto_lst = 1'b0;
    w_sto_bus = '0;
    case (state_q)
      ST_IDLE: begin
        if (w_bsi_xfer) state_d = ST_HDR;
      end
      ST_HDR: begin
        w_sto_vld = 1'b1;
        w_sto_bus = seq_q ? SW'(HDR_SEQ) : SW'(HDR_FULL);
        if (bus.sto_rdy) begin
          state_d = seq_q ? ST_DAT : ST_ADR;
          cnt_d   = '0;
        end
      end
      ST_ADR: begin
        w_sto_vld = 1'b1;
        w_sto_bus = w_adr_beat;
        if (bus.sto_rdy) begin
          if (cnt_q == ADR_LAST) begin
            state_d = ST_DAT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DAT: begin
        w_sto_vld = 1'b1;
        w_sto_bus = w_dat_beat;
`ifndef BUS_STREAM_SER_CHK_EN
        w_sto_lst = (cnt_q == DAT_LAST);
`endif
        if (bus.sto_rdy) begin
          if (cnt_q == DAT_LAST) begin
`ifdef BUS_STREAM_SER_CHK_EN
            state_d = ST_CHK;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_CHK: begin
        w_sto_vld = 1'b1;
        w_sto_lst = 1'b1;
        w_sto_bus = w_chk_beat;
        if (bus.sto_rdy) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.bsi_rdy = rdy_q;
  assign bus.sto_vld = w_sto_vld;
  assign bus.sto_lst = w_sto_lst;
  assign bus.sto_bus = w_sto_bus;

endmodule
`default_nettype wire

// File: tb/tb_bus_stream_ser.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_stream_ser
// Brief   : Directed self-checking bench for bus_stream_ser (AW=DW=32, SW=8).
// Revision: 1.0 - initial release
// ============================================================================
module tb_bus_stream_ser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] rx_bus[$];
  logic       rx_lst[$];
  int         rx_cycles;
  logic [7:0] st_bus[$];
  logic       st_lst[$];
  logic       st_vld[$];

  always #5 clk = ~clk;

  bus_stream_ser_if #(.AW(32), .DW(32), .SW(8)) bif ();

  bus_stream_ser #(.AW(32), .DW(32), .SW(8), .SEQ(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  function automatic logic [7:0] xor_of(input logic [7:0] q[$]);
    logic [7:0] x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] adr, input logic [31:0] dat);
    int t = 0;
    while (bif.bsi_rdy !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    checks++;
    if (bif.bsi_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rdy_wait: bsi_rdy=%b required 1 within 20 cycles", bif.bsi_rdy);
    end
    bif.bsi_vld = 1'b1;
    bif.bsi_adr = adr;
    bif.bsi_dat = dat;
    step();
    bif.bsi_vld = 1'b0;
  endtask

  // Gathers one packet; optionally holds sto_rdy low for stall_len cycles at beat stall_idx
  task automatic collect(input int stall_idx, input int stall_len);
    int cyc = 0;
    int stalls = 0;
    bit done = 1'b0;
    rx_bus.delete(); rx_lst.delete();
    st_bus.delete(); st_lst.delete(); st_vld.delete();
    while (!done && cyc < 40) begin
      if (rx_bus.size() == stall_idx && stalls < stall_len) begin
        bif.sto_rdy = 1'b0;
        st_bus.push_back(bif.sto_bus);
        st_lst.push_back(bif.sto_lst);
        st_vld.push_back(bif.sto_vld);
        stalls++;
      end else begin
        bif.sto_rdy = 1'b1;
        if (bif.sto_vld === 1'b1) begin
          rx_bus.push_back(bif.sto_bus);
          rx_lst.push_back(bif.sto_lst);
          if (bif.sto_lst === 1'b1) done = 1'b1;
        end
      end
      step();
      cyc++;
    end
    bif.sto_rdy = 1'b1;
    rx_cycles = cyc;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL collect_timeout: no sto_lst seen after %0d cycles, required one", cyc);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bif.sto_vld !== 1'b0 || bif.bsi_rdy !== 1'b0 || bif.sto_lst !== 1'b0 || bif.sto_bus !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold%0d: vld=%b rdy=%b lst=%b bus=%h required 0 0 0 00",
                 i, bif.sto_vld, bif.bsi_rdy, bif.sto_lst, bif.sto_bus);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (bif.bsi_rdy !== 1'b1 || bif.sto_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b vld=%b required 1 0", bif.bsi_rdy, bif.sto_vld);
    end
  endtask

  task automatic test_full_packet();
    logic [7:0] exp[$];
    exp = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
`ifdef BUS_STREAM_SER_CHK_EN
    exp.push_back(xor_of(exp));
`endif
    bus_write(32'h0000_0010, 32'hAABB_CCDD);
    checks++;
    if (bif.sto_vld !== 1'b1 || bif.sto_bus !== 8'h01 || bif.bsi_rdy !== 1'b0) begin
      errors++;
      $display("FAIL full_latency: vld=%b bus=%h rdy=%b required 1 01 0",
               bif.sto_vld, bif.sto_bus, bif.bsi_rdy);
    end
    collect(-1, 0);
    checks++;
    if (rx_bus.size() != exp.size() || rx_cycles != exp.size()) begin
      errors++;
      $display("FAIL full_len: beats=%0d cycles=%0d required %0d", rx_bus.size(), rx_cycles, exp.size());
    end
    for (int i = 0; i < exp.size() && i < rx_bus.size(); i++) begin
      checks++;
      if (rx_bus[i] !== exp[i] || rx_lst[i] !== (i == exp.size() - 1)) begin
        errors++;
        $display("FAIL full_beat%0d: got %h lst=%b required %h lst=%b",
                 i, rx_bus[i], rx_lst[i], exp[i], (i == exp.size() - 1));
      end
    end
    checks++;
    if (bif.bsi_rdy !== 1'b1) begin
      errors++;
      $display("FAIL full_rdy_back: bsi_rdy=%b required 1", bif.bsi_rdy);
    end
  endtask

  task automatic test_seq_packet();
    logic [7:0] exp[$];
    exp = '{8'h02, 8'h44, 8'h33, 8'h22, 8'h11};
`ifdef BUS_STREAM_SER_CHK_EN
    exp.push_back(8'h46);
`endif
    bus_write(32'h0000_0011, 32'h1122_3344);
    collect(-1, 0);
    checks++;
    if (rx_bus.size() != exp.size() || rx_cycles != exp.size()) begin
      errors++;
      $display("FAIL seq_len: beats=%0d cycles=%0d required %0d", rx_bus.size(), rx_cycles, exp.size());
    end
    for (int i = 0; i < exp.size() && i < rx_bus.size(); i++) begin
      checks++;
      if (rx_bus[i] !== exp[i] || rx_lst[i] !== (i == exp.size() - 1)) begin
        errors++;
        $display("FAIL seq_beat%0d: got %h lst=%b required %h lst=%b",
                 i, rx_bus[i], rx_lst[i], exp[i], (i == exp.size() - 1));
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] adrs[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0020};
    logic [7:0]  hdrs[3] = '{8'h01, 8'h02, 8'h01};
    int          lens[3] = '{9, 5, 9};
    for (int k = 0; k < 3; k++) begin
      bus_write(adrs[k], 32'h1234_5678 + k);
      collect(-1, 0);
      checks++;
      if (rx_bus.size() == 0 || rx_bus[0] !== hdrs[k] ||
          rx_bus.size() != lens[k] + ((k == 0) ? 0 : 0) + `ifdef BUS_STREAM_SER_CHK_EN 1 `else 0 `endif) begin
        errors++;
        $display("FAIL wrap_pkt%0d: hdr=%h beats=%0d required hdr=%h",
                 k, (rx_bus.size() != 0) ? rx_bus[0] : 8'hxx, rx_bus.size(), hdrs[k]);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp[$];
    exp = '{8'h01, 8'h40, 8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
`ifdef BUS_STREAM_SER_CHK_EN
    exp.push_back(xor_of(exp));
`endif
    bus_write(32'h0000_0040, 32'h0102_0304);
    collect(1, 3);
    checks++;
    if (st_vld.size() != 3) begin
      errors++;
      $display("FAIL stall_count: stalled cycles=%0d required 3", st_vld.size());
    end
    for (int i = 0; i < st_vld.size(); i++) begin
      checks++;
      if (st_vld[i] !== 1'b1 || st_bus[i] !== 8'h40 || st_lst[i] !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: vld=%b bus=%h lst=%b required 1 40 0",
                 i, st_vld[i], st_bus[i], st_lst[i]);
      end
    end
    checks++;
    if (rx_bus.size() != exp.size()) begin
      errors++;
      $display("FAIL stall_len: beats=%0d required %0d", rx_bus.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < rx_bus.size(); i++) begin
      checks++;
      if (rx_bus[i] !== exp[i] || rx_lst[i] !== (i == exp.size() - 1)) begin
        errors++;
        $display("FAIL stall_beat%0d: got %h lst=%b required %h lst=%b",
                 i, rx_bus[i], rx_lst[i], exp[i], (i == exp.size() - 1));
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] exp[$];
    exp = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'h00, 8'h00};
`ifdef BUS_STREAM_SER_CHK_EN
    exp.push_back(xor_of(exp));
`endif
    bus_write(32'h0000_0041, 32'h5566_7788);
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (bif.sto_vld !== 1'b0 || bif.bsi_rdy !== 1'b0 || bif.sto_lst !== 1'b0 || bif.sto_bus !== 8'h00) begin
      errors++;
      $display("FAIL midrst_outputs: vld=%b rdy=%b lst=%b bus=%h required 0 0 0 00",
               bif.sto_vld, bif.bsi_rdy, bif.sto_lst, bif.sto_bus);
    end
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if (bif.bsi_rdy !== 1'b1 || bif.sto_vld !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release: rdy=%b vld=%b required 1 0", bif.bsi_rdy, bif.sto_vld);
    end
    bus_write(32'h0000_0042, 32'h0000_BEEF);
    collect(-1, 0);
    checks++;
    if (rx_bus.size() != exp.size()) begin
      errors++;
      $display("FAIL midrst_len: beats=%0d required %0d", rx_bus.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < rx_bus.size(); i++) begin
      checks++;
      if (rx_bus[i] !== exp[i] || rx_lst[i] !== (i == exp.size() - 1)) begin
        errors++;
        $display("FAIL midrst_beat%0d: got %h lst=%b required %h lst=%b",
                 i, rx_bus[i], rx_lst[i], exp[i], (i == exp.size() - 1));
      end
    end
  endtask

  initial begin
    bif.bsi_vld = 1'b0;
    bif.bsi_adr = '0;
    bif.bsi_dat = '0;
    bif.sto_rdy = 1'b1;
    test_reset();
    test_full_packet();
    test_seq_packet();
    test_wrap();
    test_stall();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
